// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int N_REQ_MAX   = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, searching circularly.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               pick_valid,
    output logic [GRANT_W-1:0] pick_id
);

    logic [N_REQ-1:0]   rot_s;
    logic [GRANT_W-1:0] idx_s;
    logic               hit_s;
    logic [GRANT_W-1:0] off_s;

    // Rotate the request vector so that the rr_ptr position lands on bit 0.
    always_comb begin
        rot_s = {N_REQ{1'b0}};
        idx_s = {GRANT_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx_s    = GRANT_W'((int'(rr_ptr) + k) % N_REQ);
            rot_s[k] = req[idx_s];
        end
    end

    // Priority-encode the rotated vector, lowest offset wins.
    always_comb begin
        hit_s = 1'b0;
        off_s = {GRANT_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit_s && rot_s[k]) begin
                hit_s = 1'b1;
                off_s = GRANT_W'(k);
            end else begin
                off_s = off_s;
            end
        end
    end

    assign pick_valid = hit_s;
    assign pick_id    = GRANT_W'((int'(rr_ptr) + int'(off_s)) % N_REQ);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_top transmitter among N_REQ byte requesters.
// Optional burst lock is compiled in with the macro UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    localparam int GRANT_W = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [N_REQ-1:0]             req_lock,
    output logic [N_REQ-1:0]             req_ack,
    output logic                         grant_valid,
    output logic [GRANT_W-1:0]           grant_id,
    output logic [UART_BYTE_W-1:0]       tx_data,
    output logic                         tx_send,
    input  logic                         tx_busy
);

    arb_state_e             state_r;
    arb_state_e             state_s;
    logic [GRANT_W-1:0]     rr_ptr_r;
    logic [GRANT_W-1:0]     rr_ptr_s;
    logic [GRANT_W-1:0]     grant_id_r;
    logic [GRANT_W-1:0]     grant_id_s;
    logic                   grant_valid_r;
    logic                   grant_valid_s;
    logic [UART_BYTE_W-1:0] tx_data_r;
    logic [UART_BYTE_W-1:0] tx_data_s;
    logic                   tx_send_r;
    logic                   tx_send_s;
    logic [N_REQ-1:0]       req_ack_r;
    logic [N_REQ-1:0]       req_ack_s;

    logic                   pick_valid_s;
    logic [GRANT_W-1:0]     pick_id_s;
    logic                   relock_s;
    logic                   lock_keep_s;
    logic [GRANT_W-1:0]     sel_id_s;
    logic [GRANT_W-1:0]     rr_next_s;
    logic [N_REQ-1:0]       owner_hot_s;
    logic [UART_BYTE_W-1:0] req_byte_s [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_byte_s[g] = req_data[g*UART_BYTE_W +: UART_BYTE_W];
    end

    uart_rr_picker #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_r),
        .pick_valid (pick_valid_s),
        .pick_id    (pick_id_s)
    );

`ifdef UART_ARB_LOCK_EN
    // A grant still valid in IDLE means the owner held the transmitter through a locked byte.
    assign relock_s    = grant_valid_r & req[grant_id_r];
    assign lock_keep_s = req_lock[grant_id_r] & req[grant_id_r];
`else
    logic unused_lock_s;
    assign unused_lock_s = ^req_lock;
    assign relock_s      = 1'b0;
    assign lock_keep_s   = 1'b0;
`endif

    assign sel_id_s    = relock_s ? grant_id_r : pick_id_s;
    assign rr_next_s   = (grant_id_r == GRANT_W'(N_REQ - 1)) ? {GRANT_W{1'b0}}
                                                               : grant_id_r + GRANT_W'(1);
    assign owner_hot_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_r;

    // Next-state and next-output logic for the grant / send / busy-tracking sequence.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        grant_id_s    = grant_id_r;
        grant_valid_s = grant_valid_r;
        tx_data_s     = tx_data_r;
        tx_send_s     = 1'b0;
        req_ack_s     = {N_REQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (relock_s || pick_valid_s) begin
                    grant_id_s    = sel_id_s;
                    tx_data_s     = req_byte_s[sel_id_s];
                    grant_valid_s = 1'b1;
                    state_s       = SEND;
                end else begin
                    grant_valid_s = 1'b0;
                    state_s       = IDLE;
                end
            end
            SEND: begin
                tx_send_s = 1'b1;
                state_s   = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_START;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    req_ack_s = owner_hot_s;
                    state_s   = IDLE;
                    if (lock_keep_s) begin
                        grant_valid_s = 1'b1;
                    end else begin
                        rr_ptr_s      = rr_next_s;
                        grant_valid_s = 1'b0;
                    end
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s       = IDLE;
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns to IDLE with every output cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            rr_ptr_r      <= {GRANT_W{1'b0}};
            grant_id_r    <= {GRANT_W{1'b0}};
            grant_valid_r <= 1'b0;
            tx_data_r     <= {UART_BYTE_W{1'b0}};
            tx_send_r     <= 1'b0;
            req_ack_r     <= {N_REQ{1'b0}};
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            grant_id_r    <= grant_id_s;
            grant_valid_r <= grant_valid_s;
            tx_data_r     <= tx_data_s;
            tx_send_r     <= tx_send_s;
            req_ack_r     <= req_ack_s;
        end
    end

    assign req_ack     = req_ack_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign tx_data     = tx_data_r;
    assign tx_send     = tx_send_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART transmitter and loopback receiver.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int CPB = 104;   // 1 MHz clock, 9600 baud
    localparam int TMO = 8000;
`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ack;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_lock(req_lock),
        .req_ack(req_ack), .grant_valid(grant_valid), .grant_id(grant_id),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART transmitter: start bit, 8 data bits LSB first, stop bit, CPB clocks each.
    logic       u_busy;
    logic       u_line;
    logic [9:0] u_shift;
    int         u_cnt;
    int         u_bit;
    assign tx_busy = u_busy;

    always @(posedge clk) begin
        if (reset) begin
            u_busy <= 1'b0; u_line <= 1'b1; u_cnt <= 0; u_bit <= 0;
        end else if (!u_busy) begin
            if (tx_send) begin
                u_shift <= {1'b1, tx_data, 1'b0};
                u_busy  <= 1'b1; u_line <= 1'b0; u_cnt <= 0; u_bit <= 0;
            end
        end else if (u_cnt == CPB - 1) begin
            u_cnt <= 0;
            if (u_bit == 9) begin
                u_busy <= 1'b0; u_line <= 1'b1;
            end else begin
                u_bit  <= u_bit + 1;
                u_line <= u_shift[u_bit + 1];
            end
        end else begin
            u_cnt <= u_cnt + 1;
        end
    end

    // Loopback receiver sampling mid-bit; completed bytes go into rx_mem.
    logic       r_act;
    int         r_cnt;
    logic [7:0] r_sh;
    logic [7:0] rx_mem [64];
    int         rx_n = 0;

    always @(posedge clk) begin
        if (reset) begin
            r_act <= 1'b0; r_cnt <= 0;
        end else if (!r_act) begin
            if (u_line === 1'b0) begin r_act <= 1'b1; r_cnt <= 0; end
        end else begin
            r_cnt <= r_cnt + 1;
            if (r_cnt >= CPB/2 + CPB && r_cnt <= CPB/2 + 8*CPB && ((r_cnt - CPB/2) % CPB) == 0)
                r_sh <= {u_line, r_sh[7:1]};
            if (r_cnt == CPB/2 + 9*CPB) begin
                r_act <= 1'b0;
                if (rx_n < 64) begin rx_mem[rx_n] <= r_sh; rx_n <= rx_n + 1; end
            end
        end
    end

    // Event logs filled by the compare process.
    int         g_log [64];
    int         send_cyc [64];
    logic [3:0] a_log [64];
    int         ack_cyc [64];
    int         g_n = 0;
    int         a_n = 0;
    int         send_hi = 0;

    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int k = 0; k < N; k++) if (r[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // Transaction-level reference model and per-cycle compare.
    int         m_owner, m_age, m_rr, m_w;
    bit         m_seen, m_relock, m_full;
    logic       exp_send, exp_gv;
    logic [3:0] exp_ack;
    int         exp_gid;
    logic [7:0] exp_data;
    logic [N-1:0]   s_req, s_lock;
    logic [N*8-1:0] s_data;
    logic           s_busy;

    initial begin
        m_owner = -1; m_rr = 0; m_age = 0; m_seen = 1'b0; m_relock = 1'b0; m_full = 1'b0;
        exp_gv = 1'b0; exp_gid = 0; exp_data = 8'h00;
        forever begin
            @(posedge clk);
            s_req = req; s_lock = req_lock; s_data = req_data; s_busy = tx_busy;
            exp_send = 1'b0;
            exp_ack  = 4'b0000;
            if (reset) begin
                m_owner = -1; m_rr = 0; m_relock = 1'b0; m_full = 1'b1;
                exp_gv = 1'b0; exp_gid = 0; exp_data = 8'h00;
            end else begin
                m_full = 1'b0;
                if (m_owner < 0 || m_relock) begin
                    if (m_relock && s_req[m_owner]) m_w = m_owner;
                    else m_w = pick(s_req, m_rr);
                    m_relock = 1'b0;
                    if (m_w >= 0) begin
                        m_owner = m_w; m_age = 0; m_seen = 1'b0;
                        exp_gv = 1'b1; exp_gid = m_w; exp_data = s_data[8*m_w +: 8];
                    end else begin
                        m_owner = -1; exp_gv = 1'b0;
                    end
                end else begin
                    m_age++;
                    if (m_age == 1) exp_send = 1'b1;
                    else if (!m_seen) m_seen = s_busy;
                    else if (!s_busy) begin
                        exp_ack = 4'b0001 << m_owner;
                        if (LOCK && s_lock[m_owner] && s_req[m_owner]) m_relock = 1'b1;
                        else begin
                            m_rr = (m_owner + 1) % N; m_owner = -1; exp_gv = 1'b0;
                        end
                    end
                end
            end
            @(negedge clk);
            if (m_full) begin
                check("reset_tx_send", 32'(tx_send), 32'd0);
                check("reset_req_ack", 32'(req_ack), 32'd0);
                check("reset_grant_valid", 32'(grant_valid), 32'd0);
                check("reset_grant_id", 32'(grant_id), 32'd0);
                check("reset_tx_data", 32'(tx_data), 32'd0);
            end else begin
                check("tx_send", 32'(tx_send), 32'(exp_send));
                check("req_ack", 32'(req_ack), 32'(exp_ack));
                check("grant_valid", 32'(grant_valid), 32'(exp_gv));
                if (exp_gv) check("grant_id", 32'(grant_id), 32'(exp_gid));
                if (exp_send) check("tx_data", 32'(tx_data), 32'(exp_data));
            end
            if (tx_send === 1'b1) begin
                send_hi++;
                if (g_n < 64) begin g_log[g_n] = int'(grant_id); send_cyc[g_n] = cyc; g_n++; end
            end
            if (req_ack !== 4'b0000 && a_n < 64) begin
                a_log[a_n] = req_ack; ack_cyc[a_n] = cyc; a_n++;
            end
        end
    end

    // Requester byte queues: {lock, byte}; the head is presented until acked.
    logic [8:0] bmem [N][16];
    int         bhead [N];
    int         btail [N];

    task automatic push(input int i, input logic [7:0] b, input logic lk);
        bmem[i][btail[i]] = {lk, b};
        btail[i]++;
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_ack[i] === 1'b1 && bhead[i] != btail[i]) bhead[i]++;
            if (bhead[i] != btail[i]) begin
                req[i] = 1'b1;
                req_data[8*i +: 8] = bmem[i][bhead[i]][7:0];
                req_lock[i] = bmem[i][bhead[i]][8];
            end else begin
                req[i] = 1'b0;
                req_lock[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        tick();
        while ((req !== 4'b0000 || grant_valid !== 1'b0 || tx_busy !== 1'b0) && k < TMO) begin
            tick(); k++;
        end
        check({name, "_idle_timeout"}, 32'(k < TMO), 32'd1);
        repeat (3) tick();
    endtask

    task automatic wait_send(input string name);
        int k = 0;
        while (tx_send !== 1'b1 && k < 200) begin tick(); k++; end
        check({name, "_send_timeout"}, 32'(k < 200), 32'd1);
    endtask

    int         bg, ba, br, bs;
    int         exp3_g [5];
    logic [7:0] exp3_d [5];
    int         exp6_g [4];
    logic [7:0] exp6_d [4];

    initial begin
        int k;
        reset = 1'b1; req = 4'b0000; req_lock = 4'b0000; req_data = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single request from requester 2.
        bg = g_n; ba = a_n; br = rx_n; bs = send_hi;
        push(2, 8'h55, 1'b0);
        wait_idle("t1");
        check("t1_grant_id", 32'(g_log[bg]), 32'd2);
        check("t1_n_grants", 32'(g_n - bg), 32'd1);
        check("t1_ack", 32'(a_log[ba]), 32'b0100);
        check("t1_n_acks", 32'(a_n - ba), 32'd1);
        check("t1_send_cycles", 32'(send_hi - bs), 32'd1);
        check("t1_rx", 32'(rx_mem[br]), 32'h55);

        // Simultaneous requests straight from reset.
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        bg = g_n; ba = a_n; br = rx_n;
        push(0, 8'hAA, 1'b0); push(3, 8'h55, 1'b0);
        wait_idle("t2");
        check("t2_grant0", 32'(g_log[bg]), 32'd0);
        check("t2_grant1", 32'(g_log[bg+1]), 32'd3);
        check("t2_ack0", 32'(a_log[ba]), 32'b0001);
        check("t2_ack1", 32'(a_log[ba+1]), 32'b1000);
        check("t2_rx0", 32'(rx_mem[br]), 32'hAA);
        check("t2_rx1", 32'(rx_mem[br+1]), 32'h55);

        // Fairness: all four held, requester 0 has a second byte.
        bg = g_n; br = rx_n;
        exp3_g = '{0, 1, 2, 3, 0};
        exp3_d = '{8'h00, 8'hFF, 8'h11, 8'h22, 8'h00};
        push(0, 8'h00, 1'b0); push(1, 8'hFF, 1'b0); push(2, 8'h11, 1'b0);
        push(3, 8'h22, 1'b0); push(0, 8'h00, 1'b0);
        wait_idle("t3");
        for (int i = 0; i < 5; i++) begin
            check("t3_grant", 32'(g_log[bg+i]), 32'(exp3_g[i]));
            check("t3_rx", 32'(rx_mem[br+i]), 32'(exp3_d[i]));
        end

        // Owner drops req after tx_send; requester 1 arrives mid-frame.
        bg = g_n; ba = a_n; br = rx_n;
        push(0, 8'h5A, 1'b0);
        wait_send("t4");
        bhead[0] = btail[0];
        k = 0;
        while (tx_busy !== 1'b1 && k < 200) begin tick(); k++; end
        check("t4_busy_timeout", 32'(k < 200), 32'd1);
        repeat (5) tick();
        push(1, 8'hC3, 1'b0);
        wait_idle("t4");
        check("t4_ack0", 32'(a_log[ba]), 32'b0001);
        check("t4_grant1", 32'(g_log[bg+1]), 32'd1);
        check("t4_ack_to_send", 32'(send_cyc[bg+1] - ack_cyc[ba]), 32'd2);
        check("t4_rx0", 32'(rx_mem[br]), 32'h5A);
        check("t4_rx1", 32'(rx_mem[br+1]), 32'hC3);

        // Reset during bit 4 of 0xFF from requester 2 (rr_ptr is 2 beforehand).
        push(2, 8'hFF, 1'b0);
        k = 0;
        while (!(u_busy === 1'b1 && u_bit == 4) && k < 2000) begin tick(); k++; end
        check("t5_bit4_timeout", 32'(k < 2000), 32'd1);
        tick();
        reset = 1'b1;
        bhead[2] = btail[2];
        tick();
        check("t5_tx_send", 32'(tx_send), 32'd0);
        check("t5_req_ack", 32'(req_ack), 32'd0);
        check("t5_grant_valid", 32'(grant_valid), 32'd0);
        check("t5_grant_id", 32'(grant_id), 32'd0);
        check("t5_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        bg = g_n; br = rx_n;
        push(1, 8'h3C, 1'b0); push(3, 8'h96, 1'b0);
        wait_idle("t5");
        check("t5_grant0", 32'(g_log[bg]), 32'd1);
        check("t5_grant1", 32'(g_log[bg+1]), 32'd3);
        check("t5_rx0", 32'(rx_mem[br]), 32'h3C);
        check("t5_rx1", 32'(rx_mem[br+1]), 32'h96);

        // Burst from requester 2 with lock on the first two bytes, requester 0 pending.
`ifdef UART_ARB_LOCK_EN
        exp6_g = '{2, 2, 2, 0};
        exp6_d = '{8'hA1, 8'hA2, 8'hA3, 8'h0F};
`else
        exp6_g = '{2, 0, 2, 2};
        exp6_d = '{8'hA1, 8'h0F, 8'hA2, 8'hA3};
`endif
        bg = g_n; br = rx_n;
        push(2, 8'hA1, 1'b1);
        wait_send("t6");
        push(0, 8'h0F, 1'b0); push(2, 8'hA2, 1'b1); push(2, 8'hA3, 1'b0);
        wait_idle("t6");
        for (int i = 0; i < 4; i++) begin
            check("t6_grant", 32'(g_log[bg+i]), 32'(exp6_g[i]));
            check("t6_rx", 32'(rx_mem[br+i]), 32'(exp6_d[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_top` transmitter among `N_REQ` byte requesters. It sits between the requesters and the `tx_data`/`tx_send`/`tx_busy` port of `uart_top`. It latches the winning requester's byte, issues a one-cycle `tx_send`, tracks `tx_busy` through the frame, and returns a one-cycle acknowledge to the winner when the frame completes.

## Interface
- `N_REQ`, 4, number of requesters; legal range 2..16.
- `GRANT_W`, `$clog2(N_REQ)`, width of the grant index; derived, not overridden.
- `clk`  in  1  system clock; the same clock as `uart_top`.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request; held high until the matching `req_ack` pulse.
- `req_data`  in  N_REQ*8  byte for requester i at `[8*i+7:8*i]`; stable while `req[i]` is high.
- `req_lock`  in  N_REQ  per-requester burst lock; used only with `UART_ARB_LOCK_EN`.
- `req_ack`  out  N_REQ  one-hot, one-cycle pulse: the granted byte's frame is complete.
- `grant_valid`  out  1  a transfer is in progress.
- `grant_id`  out  GRANT_W  index of the current owner; valid while `grant_valid` is high.
- `tx_data`  out  8  byte to `uart_top`; registered.
- `tx_send`  out  1  one-cycle send strobe to `uart_top`.
- `tx_busy`  in  1  busy flag from `uart_top`.

## Operation
- The FSM has four states: IDLE, SEND, WAIT_START and WAIT_DONE.
- **IDLE:** if `req != 0`, pick the first set bit at or after `rr_ptr`, searching circularly.
  - Latch `grant_id` and the selected byte into `tx_data`.
  - Set `grant_valid`, then go to SEND.
- **SEND:** `tx_send` is 1 for exactly this cycle; go to WAIT_START.
- **WAIT_START:** wait for `tx_busy == 1`, then go to WAIT_DONE.
  - There is no timeout. `uart_top` is required to raise `tx_busy` after a `tx_send`.
- **WAIT_DONE:** wait for `tx_busy == 0`. In that same cycle:
  - pulse `req_ack[grant_id]`;
  - set `rr_ptr = (grant_id + 1) mod N_REQ`;
  - clear `grant_valid` and return to IDLE.
- Arbitration happens only in IDLE. A request raised mid-frame waits; the owner is never pre-empted.
- If the owner drops `req` mid-frame, the frame still completes and `req_ack` still pulses. The requester must ignore that ack.
- `req_data` is sampled once, in IDLE. Later changes to `req_data` have no effect on the frame in flight.
- `rr_ptr` wrap-around: an owner at index `N_REQ-1` sets `rr_ptr` to 0.
- **Reset**, including mid-frame: state goes to IDLE, and `rr_ptr`, `tx_data`, `tx_send`, `req_ack`, `grant_valid` and `grant_id` all go to 0. `uart_top` shares `reset`, so its in-flight frame is aborted too.

## Timing
- Request-to-send latency: `req` is seen high at edge t, and `tx_send` is high for the cycle after edge t+1.
- The minimum cycle count from grant to ack is 3 plus the frame length.
- Ack to the next `tx_send` is 2 cycles: IDLE then SEND.
- Back-to-back frames therefore leave at least 1 idle cycle between `tx_busy` falling and the next `tx_send`.
- Ack and re-request in the same cycle: the requester may keep `req` high for its next byte.
  - That byte is re-arbitrated with `rr_ptr` already advanced past this requester.

## Configuration
- Macro: `UART_ARB_LOCK_EN`.
- **Defined:** in WAIT_DONE, if `req_lock[grant_id]` and `req[grant_id]` are both high when `tx_busy` falls:
  - `req_ack` pulses, but `rr_ptr` is not advanced;
  - `grant_valid` stays high and the FSM goes straight to IDLE-with-owner, selecting the same requester next cycle.
  - The owner keeps the transmitter until it sends a byte with `req_lock` low.
- **Undefined:** `req_lock` is ignored (left unconnected internally) and arbitration is pure round-robin.

## Structure
- The package `uart_arb_pkg` holds:
  - the FSM state enum (IDLE, SEND, WAIT_START, WAIT_DONE);
  - the constants `UART_BYTE_W = 8` and `N_REQ_MAX = 16`.
- The sub-module `uart_rr_picker` is combinational. It takes `req` and `rr_ptr` and returns `pick_valid` and `pick_id` (rotate, priority-encode, un-rotate).
- `uart_tx_arbiter` holds the FSM, registers and lock logic.

## Test plan
- **Single request:** `N_REQ=4`, `clk_freq=1000000`, `baud_rate=9600`, `req[2]` with 0x55.
  - Required: `tx_send` one cycle; `rx_data` = 0x55 via loopback; `req_ack = 4'b0100` once; `grant_id` = 2.
- **Simultaneous requests from reset:** `req[0]` = 0xAA and `req[3]` = 0x55.
  - Required: 0xAA is sent first, then 0x55; acks pulse in the order 0 then 3.
- **Fairness:** all four requesters held with 0x00, 0xFF, 0x11, 0x22.
  - Required: grants go 0,1,2,3,0; no requester is granted twice before the others are served.
- **Mid-frame request and drop:** `req[1]` is raised while requester 0 is in WAIT_DONE, and `req[0]` is dropped after `tx_send`.
  - Required: frame 0 completes, `req_ack[0]` pulses, and requester 1 is granted 2 cycles later.
- **Reset mid-frame:** `reset` is asserted during bit 4 of 0xFF.
  - Required: the next cycle shows all outputs at 0 and IDLE; a new request after reset is granted from `rr_ptr` = 0.
- **Lock (`UART_ARB_LOCK_EN`):** requester 2 sends 3 bytes with `req_lock` high except on the last, while `req[0]` is pending.
  - Required: the 3 bytes go back-to-back, then requester 0 is granted. Without the macro, the order is 2,0,2,2.
